spi_tx_scheduler: RTL and testbench
===================================

Name: spi_tx_scheduler

Overview:
- Upstream feeder for the 8-bit SPI master. Buffers bytes and their per-byte SPI mode from a valid/ready producer in a small FIFO.
- Launches one master transfer per entry by driving start/din/mode.
- Holds din/mode stable for the whole transfer and detects completion from the master's SS output.
- Provides a gap guard between transfers, a launch timeout, and a completed-transfer counter.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
GAP, 2, minimum idle cycles after SS returns high before the next start
TIMEOUT, 64, max cycles start may stay asserted without SS falling

Ports:
clk  input  1  rising-edge clock, shared with spi_master
reset  input  1  synchronous active-high reset
s_valid  input  1  producer byte valid
s_data  input  8  producer byte
s_mode  input  2  SPI mode for this byte
s_ready  output  1  FIFO can accept
start  output  1  to spi_master start
din  output  8  to spi_master din
mode  output  2  to spi_master mode
ss  input  1  SS observed from spi_master
busy  output  1  transfer in flight (LAUNCH/WAIT_HIGH/GAP)
tx_count  output  8  completed transfers, wraps 255->0
timeout_err  output  1  sticky launch-timeout flag

Behaviour:
- Reset values (all registered outputs): start=0, din=0, mode=0, busy=0, tx_count=0, timeout_err=0. FIFO empty. FSM=IDLE.
- s_ready=0 while reset is high. Otherwise s_ready = (occupancy < DEPTH), combinational.
- Push on s_valid & s_ready; entry stores {s_mode, s_data}.
- Occupancy width is clog2(DEPTH)+1. Read/write pointers wrap modulo DEPTH.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance. On full, no push can occur.
- FSM states: IDLE, LAUNCH, WAIT_HIGH, GAP.
- IDLE:
  - If FIFO not empty and ss==1 (X/0 does not qualify), go to LAUNCH next cycle.
  - On that same edge, register din/mode from the FIFO head and set start=1.
- LAUNCH:
  - start stays 1 and a timeout counter increments each cycle.
  - If ss==0: start<=0, go to WAIT_HIGH.
  - Else if the counter reaches TIMEOUT: start<=0, pop the entry, timeout_err<=1, go to GAP. tx_count is not incremented.
- WAIT_HIGH:
  - din/mode held.
  - On ss==1: pop the head, tx_count<=tx_count+1, go to GAP.
- GAP: count GAP cycles, then go to IDLE.
- din/mode change only on entering LAUNCH. They are stable from start rise through ss rise.
- busy=1 in LAUNCH, WAIT_HIGH and GAP.
- The pop occurs exactly once per launched entry, on the cycle the state leaves WAIT_HIGH or LAUNCH (timeout).
- Reset mid-transfer: everything returns to reset values on the next edge and FIFO contents are discarded. The master is reset by the same signal.
- ss rising while in LAUNCH: not an event; only ss==0 advances LAUNCH.
- ss going low in IDLE/GAP: ignored; no launch occurs until ss==1.
- timeout_err is cleared only by reset.
- Latency:
  - Push into an empty FIFO, with ss==1 and FSM in IDLE: start=1 two cycles after the push edge (one cycle to make the FIFO non-empty, one to enter LAUNCH).
  - Back-to-back entries are separated by at least GAP+1 cycles of start=0.

Test Plan:
- Reset for 3 cycles, release; wait for ss==1 (master idle state); push 0xA5, mode 0 -> start=1 with din=0xA5, mode=0; start drops the cycle after ss falls; after ss rises, tx_count=1, FIFO empty.
- Push 4 bytes 0x01..0x04 back-to-back with mixed modes -> s_ready=0 after 4th push; bytes reach din in order 0x01..0x04 with matching modes; tx_count=4; start=0 for >= GAP+1 cycles between transfers.
- Hold ss=1 (stub master) after a push of 0x3C -> after TIMEOUT cycles start=0, timeout_err=1, entry popped, tx_count=0; a subsequent transfer with a normal master completes and timeout_err stays 1.
- FIFO full during a transfer; push attempted on the pop cycle -> push accepted only when s_ready is 1; no entry lost or duplicated; occupancy never exceeds DEPTH.
- Assert reset while in WAIT_HIGH -> next edge: start=0, busy=0, tx_count=0, s_ready=0 during reset, FIFO empty after release; no pop or count increment for the aborted byte.
- 256 completed transfers -> tx_count wraps to 0.

Source files
------------

// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler: FIFO-buffered launcher that feeds one spi_master transfer per queued byte.
module spi_tx_scheduler #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic [1:0] s_mode,
    output logic       s_ready,
    output logic       start,
    output logic [7:0] din,
    output logic [1:0] mode,
    input  logic       ss,
    output logic       busy,
    output logic [7:0] tx_count,
    output logic       timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2((TIMEOUT > GAP ? TIMEOUT : GAP) + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_LAUNCH = 2'd1, S_WAIT = 2'd2, S_GAP = 2'd3;

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   occ_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    din_q, din_d, tx_q, tx_d;
    logic [1:0]    mode_q, mode_d;
    logic          err_q, err_d, push, pop;

    assign s_ready     = !reset && (occ_q < FULL);
    assign push        = s_valid && s_ready;
    assign start       = state_q == S_LAUNCH;
    assign busy        = state_q != S_IDLE;
    assign din         = din_q;
    assign mode        = mode_q;
    assign tx_count    = tx_q;
    assign timeout_err = err_q;

    // ss is compared against explicit levels so an unknown ss never launches or completes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (occ_q != '0 && ss == 1'b1) begin
                state_d          = S_LAUNCH;
                cnt_d            = '0;
                {mode_d, din_d}  = mem_q[rptr_q];
            end
            S_LAUNCH: begin
                cnt_d = cnt_q + 1'b1;
                if (ss == 1'b0) state_d = S_WAIT;
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    pop     = 1'b1;
                    err_d   = 1'b1;
                end
            end
            S_WAIT: if (ss == 1'b1) begin
                state_d = S_GAP;
                cnt_d   = '0;
                pop     = 1'b1;
                tx_d    = tx_q + 8'd1;
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(GAP - 1)) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            mode_q  <= '0;
            tx_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            occ_q   <= occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {s_mode, s_data};
    end
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// tb_spi_tx_scheduler: scoreboard bench with a behavioural SS model of the SPI master.
module tb_spi_tx_scheduler;
    localparam int DEPTH = 4, GAP = 2, TIMEOUT = 64, XFER = 10;

    logic       clk = 1'b0, reset = 1'b1, s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [1:0] s_mode = 2'd0;
    logic       s_ready, start, busy, timeout_err, ss;
    logic [7:0] din, tx_count;
    logic [1:0] mode;
    int         checks = 0, errors = 0, done_n = 0, base = 0;
    bit         stub = 1'b0;
    logic [9:0] exp_q [$];

    spi_tx_scheduler #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_mode(s_mode),
        .s_ready(s_ready), .start(start), .din(din), .mode(mode), .ss(ss), .busy(busy),
        .tx_count(tx_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    // Master model: drops ss when it sees start while idle, raises it XFER cycles later.
    initial begin : master
        int mcnt, lowrun;
        bit have_prev, prev_start;
        logic [9:0] cap;
        logic [31:0] e;
        ss = 1'b1; mcnt = 0; lowrun = 0; have_prev = 0; prev_start = 0; cap = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                ss = 1'b1; mcnt = 0; lowrun = 0; have_prev = 0; prev_start = 0;
            end else begin
                if (start && !prev_start && have_prev) chk("gap_min", 32'(lowrun >= GAP + 1), 32'd1);
                if (start) begin lowrun = 0; have_prev = 1; end else lowrun++;
                prev_start = start;
                if (stub) ss = 1'b1;
                else if (ss && start) begin
                    ss = 1'b0; mcnt = XFER; cap = {mode, din};
                end else if (!ss) begin
                    chk("din_hold", 32'({mode, din}), 32'(cap));
                    mcnt--;
                    if (mcnt == 0) begin
                        ss = 1'b1;
                        e = exp_q.size() > 0 ? 32'(exp_q.pop_front()) : 32'hDEAD;
                        chk("xfer_data", 32'(cap), e);
                        done_n++;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_mode = m;
        while (!s_ready && n < 2000) begin @(negedge clk); n++; end
        chk("send_ready", 32'(s_ready), 32'd1);
        if (s_ready) exp_q.push_back({m, d});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (done_n < target && n < 5000) begin @(negedge clk); n++; end
        chk(tag, 32'(done_n), 32'(target));
        @(negedge clk);
    endtask

    task automatic idle_check(input string tag, input int cyc);
        int hits = 0;
        repeat (cyc) begin @(negedge clk); if (start) hits++; end
        chk(tag, 32'(hits), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_dinmode", 32'({mode, din}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx", 32'(tx_count), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(s_ready), 32'd1);
        n = 0;
        while (ss !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        // single transfer and launch latency
        send(8'hA5, 2'd0);
        chk("t1_lat1", 32'(start), 32'd0);
        @(negedge clk);
        chk("t1_start", 32'(start), 32'd1);
        chk("t1_din", 32'({mode, din}), 32'h0A5);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_start_drop", 32'(start), 32'd0);
        wait_done("t1_done", 1);
        chk("t1_tx", 32'(tx_count), 32'd1);
        idle_check("t1_empty", GAP + 4);
        // burst to full, then pushes gated by s_ready
        for (int i = 0; i < 4; i++) send(8'(i + 1), 2'(i * 3));
        chk("t2_full", 32'(s_ready), 32'd0);
        for (int i = 0; i < 4; i++) send(8'(8'h11 + i), 2'(i));
        wait_done("t2_done", 9);
        chk("t2_tx", 32'(tx_count), 32'd9);
        idle_check("t2_empty", GAP + 4);
        // launch timeout with a stuck-idle master
        stub = 1'b1;
        send(8'h3C, 2'd1);
        n = 0;
        while (!start && n < 20) begin @(negedge clk); n++; end
        chk("t3_launch", 32'(start), 32'd1);
        chk("t3_din", 32'({mode, din}), 32'h13C);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        n = 0;
        while (start && n < TIMEOUT + 20) begin n++; @(negedge clk); end
        chk("t3_len", 32'(n), 32'(TIMEOUT));
        chk("t3_err", 32'(timeout_err), 32'd1);
        chk("t3_tx", 32'(tx_count), 32'd9);
        idle_check("t3_popped", GAP + 6);
        stub = 1'b0;
        send(8'h5A, 2'd3);
        wait_done("t3_after", 10);
        chk("t3_after_tx", 32'(tx_count), 32'd10);
        chk("t3_err_sticky", 32'(timeout_err), 32'd1);
        idle_check("t3_after_empty", GAP + 4);
        // reset while waiting for ss to rise
        send(8'h77, 2'd2);
        n = 0;
        while (ss && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("t5_inflight", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_start", 32'(start), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_tx", 32'(tx_count), 32'd0);
        chk("t5_err", 32'(timeout_err), 32'd0);
        chk("t5_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        base = done_n;
        idle_check("t5_empty", 20);
        chk("t5_tx_after", 32'(tx_count), 32'd0);
        // counter wrap with irregular producer timing
        for (int i = 0; i < 255; i++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(8'(i * 7), 2'(i));
        end
        wait_done("t6_255", base + 255);
        chk("t6_tx255", 32'(tx_count), 32'd255);
        send(8'hFF, 2'd3);
        wait_done("t6_256", base + 256);
        chk("t6_wrap", 32'(tx_count), 32'd0);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
